instr_fetch_ctrl: RTL and testbench
===================================

// Module: instr_fetch_ctrl
// PURPOSE
//  Fetch sequencer for the 256x32 instruction memory. It owns the PC and drives the memory address.
//  It hands fetched words to decode with valid/stall flow control.
//  After every control-flow opcode (J/JM/BRZ/BRN) it injects NOP bubbles until execute resolves the branch.
//  Software therefore no longer hand-pads NOPs after branches. Sits between instruction memory and decode.
// PARAMETERS
//  START_PC     8'h00  PC loaded on start
//  LAST_PC      8'hFF  last fetchable address; fetch halts after it (no wrap)
//  BR_TIMEOUT   8      max bubble cycles awaiting resolve before forced not-taken
// PORTS
//  clk           in   1   clock; all state on posedge
//  rst_n         in   1   asynchronous, active-low reset
//  start         in   1   pulse: begin fetch at START_PC (honoured in IDLE/HALT only)
//  stall_in      in   1   decode backpressure: hold all outputs and state
//  br_valid      in   1   branch resolution strobe from execute
//  br_taken      in   1   resolution outcome, qualified by br_valid
//  br_target     in   8   redirect address, qualified by br_valid & br_taken
//  imem_addr     out  8   registered address to instruction memory
//  imem_data     in   32  memory word; memory samples imem_addr on negedge, valid at next posedge
//  instr_out     out  32  instruction to decode (32'h0 = NOP bubble)
//  instr_pc      out  8   address of instr_out
//  instr_valid   out  1   instr_out is a real fetch or injected bubble
//  halted        out  1   fetch stopped after LAST_PC
//  br_timeout    out  1   sticky: a branch wait timed out; cleared by reset/start
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; imem_addr=START_PC; instr_out=0; instr_pc=0; instr_valid=0; halted=0; br_timeout=0; bubble counter=0.
//  Memory timing: addr A registered at posedge k -> imem_data(A) sampled at posedge k+1. One-cycle fetch latency, no gap.
//  IDLE: instr_valid=0. On start -> FETCH, imem_addr<=START_PC, br_timeout<=0.
//  FETCH, stall_in=0, each posedge:
//   - instr_out<=imem_data; instr_pc<=imem_addr; instr_valid<=1.
//   - opcode=imem_data[31:28]. If ctrl (1000,1001,1010,1011): imem_addr<=imem_addr+1, cnt<=0, -> BRWAIT.
//   - else if imem_addr==LAST_PC: -> HALT.
//   - else imem_addr<=imem_addr+1.
//  BRWAIT, stall_in=0: instr_out<=0, instr_valid<=1 (bubble), cnt<=cnt+1; imem_addr held.
//   - br_valid&br_taken: imem_addr<=br_target, -> FETCH; target word emitted next cycle.
//   - br_valid&!br_taken: -> FETCH with held addr (branch pc+1).
//   - br_valid not seen and cnt==BR_TIMEOUT-1: br_timeout<=1, treat as not-taken -> FETCH.
//   - Branch at LAST_PC: resolve not-taken -> HALT; taken redirects normally.
//  HALT: halted=1, instr_valid<=0. start -> FETCH at START_PC, halted<=0.
//  stall_in=1: instr_out, instr_pc, instr_valid, imem_addr, cnt all hold (memory re-reads the same addr).
//   - br_valid during stall in BRWAIT is still accepted: addr/state update, outputs hold.
//  br_valid outside BRWAIT: ignored. start outside IDLE/HALT: ignored.
//  No wrap: imem_addr never increments past LAST_PC. 8-bit adds cannot overflow because of the HALT check.
//  Reset mid-fetch or mid-BRWAIT: immediate return to reset values; pending resolve is discarded.
// STRUCTURE
//  Package fetch_pkg: OP_NOP=4'b0000, OP_J=4'b1000, OP_BRZ=4'b1001, OP_JM=4'b1010, OP_BRN=4'b1011, NOP_WORD=32'h0.
//   Also holds the state encoding: IDLE, FETCH, BRWAIT, HALT.
//  Sub-module ctrl_op_detect: combinational, opcode[3:0] -> is_ctrl. Shared later with the decode hazard logic.
//  Single always block for the FSM/PC with async reset; bubble counter inside it.
// TESTING
//  1. Reset then start; mem[0..3]=ADD words; no stall -> instr_pc 0,1,2,3 on consecutive cycles, valid=1.
//  2. mem[5]=BRN; br_valid&taken, target 8'h0D, 2 cycles after BRN -> 2 NOP bubbles, then instr_pc=0x0D.
//  3. mem[8]=BRZ; not-taken resolve -> bubbles, then instr_pc=0x09; no redirect.
//  4. Branch, never resolved -> exactly 8 bubbles, br_timeout=1, fetch resumes at pc+1.
//  5. stall_in high 3 cycles mid-stream, br_valid taken during stall -> outputs frozen; target emitted first cycle after release.
//  6. LAST_PC=8'h04 -> pc 4 emitted, then halted=1, valid=0. rst_n low mid-BRWAIT -> all reset values asynchronously.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared opcode constants, FSM encoding and the registered output bundle for the fetch sequencer.
package fetch_pkg;

  localparam logic [3:0]  OP_NOP   = 4'b0000;
  localparam logic [3:0]  OP_J     = 4'b1000;
  localparam logic [3:0]  OP_BRZ   = 4'b1001;
  localparam logic [3:0]  OP_JM    = 4'b1010;
  localparam logic [3:0]  OP_BRN   = 4'b1011;
  localparam logic [31:0] NOP_WORD = 32'h0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_BRWAIT = 2'd2,
    S_HALT   = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [7:0]  pc;
    logic        valid;
  } fetch_out_t;

endpackage

// File: rtl/ctrl_op_detect.sv
// Flags control-flow opcodes; also intended for the decode hazard logic.
module ctrl_op_detect
  import fetch_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       is_ctrl
);

  assign is_ctrl = (opcode == OP_J) || (opcode == OP_BRZ) ||
                   (opcode == OP_JM) || (opcode == OP_BRN);

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, streams memory words to decode and injects
// NOP bubbles after control-flow opcodes until execute resolves the branch.
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [7:0] START_PC   = 8'h00,
  parameter logic [7:0] LAST_PC    = 8'hFF,
  parameter int         BR_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stall_in,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic [7:0]  br_target,
  output logic [7:0]  imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] instr_out,
  output logic [7:0]  instr_pc,
  output logic        instr_valid,
  output logic        halted,
  output logic        br_timeout
);

  localparam logic [7:0] CNT_LAST = 8'(BR_TIMEOUT - 1);

  fetch_state_t state;
  fetch_out_t   out_q;
  logic [7:0]   cnt;
  logic         br_at_last;
  logic         is_ctrl;
  logic         at_last;

  ctrl_op_detect u_op_det (
    .opcode  (imem_data[31:28]),
    .is_ctrl (is_ctrl)
  );

  assign at_last     = (imem_addr == LAST_PC);
  assign instr_out   = out_q.instr;
  assign instr_pc    = out_q.pc;
  assign instr_valid = out_q.valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      imem_addr  <= START_PC;
      out_q      <= '0;
      halted     <= 1'b0;
      br_timeout <= 1'b0;
      cnt        <= '0;
      br_at_last <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          out_q.valid <= 1'b0;
          if (start) begin
            state      <= S_FETCH;
            imem_addr  <= START_PC;
            halted     <= 1'b0;
            br_timeout <= 1'b0;
          end
        end
        S_FETCH: begin
          if (!stall_in) begin
            out_q <= '{instr: imem_data, pc: imem_addr, valid: 1'b1};
            if (is_ctrl) begin
              // A branch sitting on LAST_PC keeps the address; not-taken then halts.
              br_at_last <= at_last;
              if (!at_last) imem_addr <= imem_addr + 8'd1;
              cnt   <= '0;
              state <= S_BRWAIT;
            end else if (at_last) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end else begin
              imem_addr <= imem_addr + 8'd1;
            end
          end
        end
        S_BRWAIT: begin
          if (!stall_in) begin
            out_q.instr <= NOP_WORD;
            out_q.valid <= 1'b1;
            cnt         <= cnt + 8'd1;
          end
          // Resolution is accepted even while decode is stalled.
          if (br_valid && br_taken) begin
            imem_addr <= br_target;
            state     <= S_FETCH;
          end else if (br_valid || (!stall_in && cnt == CNT_LAST)) begin
            if (!br_valid) br_timeout <= 1'b1;
            if (br_at_last) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end else begin
              state <= S_FETCH;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed table-driven bench for instr_fetch_ctrl with a negedge-sampling memory model.
module tb_instr_fetch_ctrl;

  logic        clk, rst_n, start, stall_in, br_valid, br_taken;
  logic [7:0]  br_target;
  logic [7:0]  addr, addr_l, pc, pc_l;
  logic [31:0] dat, dat_l, instr, instr_l;
  logic        valid, valid_l, halted, halted_l, bto, bto_l;
  logic [31:0] mem [256];

  int checks = 0;
  int failures = 0;
  int row = -1;

  instr_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall_in(stall_in),
    .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
    .imem_addr(addr), .imem_data(dat), .instr_out(instr), .instr_pc(pc),
    .instr_valid(valid), .halted(halted), .br_timeout(bto)
  );

  instr_fetch_ctrl #(.LAST_PC(8'h04)) dut_l (
    .clk(clk), .rst_n(rst_n), .start(start), .stall_in(stall_in),
    .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
    .imem_addr(addr_l), .imem_data(dat_l), .instr_out(instr_l), .instr_pc(pc_l),
    .instr_valid(valid_l), .halted(halted_l), .br_timeout(bto_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    dat   <= mem[addr];
    dat_l <= mem[addr_l];
  end

  typedef struct {
    logic       stall, bv, bt, st, bub, eto;
    logic [7:0] tgt, epc;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic stall, logic bv, logic bt, logic [7:0] tgt,
                              logic st, logic bub, logic [7:0] epc, logic eto);
    vec_t v;
    v.stall = stall; v.bv = bv; v.bt = bt; v.tgt = tgt;
    v.st = st; v.bub = bub; v.epc = epc; v.eto = eto;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%h expected=%h", nm, row, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic bv, input logic bt, input logic [7:0] t,
                       input logic st);
    stall_in = s; br_valid = bv; br_taken = bt; br_target = t; start = st;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_addr"},   32'(addr),   32'h0);
    chk({nm, "_instr"},  instr,       32'h0);
    chk({nm, "_pc"},     32'(pc),     32'h0);
    chk({nm, "_valid"},  32'(valid),  32'h0);
    chk({nm, "_halted"}, 32'(halted), 32'h0);
    chk({nm, "_bto"},    32'(bto),    32'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 | 32'(i);
    mem[8'h05] = 32'hB000_0005;  // BRN
    mem[8'h08] = 32'h9000_0008;  // BRZ
    mem[8'h0C] = 32'h8000_000C;  // J
    mem[8'h0F] = 32'hA000_000F;  // JM

    // stream: plain fetch, taken branch, stall + resolve, not-taken, stray inputs, timeout
    for (int i = 0; i <= 5; i++) tv.push_back(mk(0, 0, 0, 0, 0, 0, 8'(i), 0));
    tv.push_back(mk(0, 0, 0, 0,     0, 1, 8'h05, 0));
    tv.push_back(mk(0, 1, 1, 8'h0D, 0, 1, 8'h05, 0));
    tv.push_back(mk(0, 0, 0, 0,     0, 0, 8'h0D, 0));
    tv.push_back(mk(0, 0, 0, 0,     0, 0, 8'h0E, 0));
    tv.push_back(mk(0, 0, 0, 0,     0, 0, 8'h0F, 0));
    tv.push_back(mk(1, 0, 0, 0,     0, 0, 8'h0F, 0));
    tv.push_back(mk(1, 1, 1, 8'h07, 0, 0, 8'h0F, 0));
    tv.push_back(mk(1, 0, 0, 0,     0, 0, 8'h0F, 0));
    tv.push_back(mk(0, 0, 0, 0,     0, 0, 8'h07, 0));
    tv.push_back(mk(0, 0, 0, 0,     0, 0, 8'h08, 0));
    tv.push_back(mk(0, 0, 0, 0,     0, 1, 8'h08, 0));
    tv.push_back(mk(0, 0, 0, 0,     0, 1, 8'h08, 0));
    tv.push_back(mk(0, 1, 0, 8'h44, 0, 1, 8'h08, 0));
    tv.push_back(mk(0, 0, 0, 0,     0, 0, 8'h09, 0));
    tv.push_back(mk(0, 1, 1, 8'h33, 0, 0, 8'h0A, 0));
    tv.push_back(mk(0, 0, 0, 0,     1, 0, 8'h0B, 0));
    tv.push_back(mk(0, 0, 0, 0,     0, 0, 8'h0C, 0));
    for (int i = 0; i < 7; i++) tv.push_back(mk(0, 0, 0, 0, 0, 1, 8'h0C, 0));
    tv.push_back(mk(0, 0, 0, 0,     0, 1, 8'h0C, 1));
    tv.push_back(mk(0, 0, 0, 0,     0, 0, 8'h0D, 1));

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (3) step();
    chk_reset("rst");
    rst_n = 1'b1;
    step();
    chk("idle_valid", 32'(valid), 32'h0);
    drive(0, 0, 0, 0, 1);
    step();
    chk("start_valid", 32'(valid), 32'h0);

    foreach (tv[i]) begin
      row = i;
      drive(tv[i].stall, tv[i].bv, tv[i].bt, tv[i].tgt, tv[i].st);
      step();
      chk("valid", 32'(valid), 32'h1);
      chk("instr", instr, tv[i].bub ? 32'h0 : mem[tv[i].epc]);
      if (!tv[i].bub) chk("pc", 32'(pc), 32'(tv[i].epc));
      chk("br_timeout", 32'(bto), 32'(tv[i].eto));
      chk("halted", 32'(halted), 32'h0);
      if (i <= 5) begin
        chk("l_valid",  32'(valid_l),  32'(i <= 4));
        chk("l_halted", 32'(halted_l), 32'(i >= 4));
        if (i <= 4) chk("l_pc", 32'(pc_l), 32'(i));
      end
    end

    // async reset while waiting on a branch; stray resolve afterwards is ignored
    row = -2;
    drive(0, 0, 0, 0, 0);
    step();
    chk("pre_pc_0e", 32'(pc), 32'h0E);
    step();
    chk("pre_pc_0f", 32'(pc), 32'h0F);
    step();
    chk("pre_bubble", instr, 32'h0);
    #2 rst_n = 1'b0;
    #1 chk_reset("async_rst");
    drive(0, 1, 1, 8'h20, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_addr",  32'(addr),  32'h0);
    chk("post_rst_valid", 32'(valid), 32'h0);
    drive(0, 0, 0, 0, 1);
    step();
    drive(0, 0, 0, 0, 0);
    step();
    chk("restart_pc",    32'(pc),    32'h0);
    chk("restart_instr", instr,      mem[0]);
    chk("restart_valid", 32'(valid), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
